// File: rtl/div_unit_if.sv
// Start/busy/done handshake and operand/result bus between the core and the divider.
interface div_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            dz;

    // Core side: issues requests, watches for completion.
    modport master (
        output start, op, A, B,
        input  busy, done, result, dz
    );

    // Divider side.
    modport slave (
        input  start, op, A, B,
        output busy, done, result, dz
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; a final cycle applies signs and registers the result.
// Divide-by-zero and signed overflow finish directly from IDLE.
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input logic       clk,
    input logic       nRst,
    div_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_t;

    state_t state_q, state_d;

    logic [1:0]      op_q;
    logic            a_neg_q;
    logic            b_neg_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [CntW-1:0] cnt_q;
    logic [XLEN-1:0] result_q;
    logic            dz_q;

    // Request decode (only meaningful in IDLE). op[0]=1 selects unsigned, op[1]=1 selects REM.
    logic            in_signed;
    logic            in_rem;
    logic            in_b_zero;
    logic            in_ovf;
    logic [XLEN-1:0] in_a_mag;
    logic [XLEN-1:0] in_b_mag;

    // Iteration datapath.
    logic [XLEN+1:0] trial;
    logic            trial_ok;
    logic [XLEN-1:0] rem_shift;
    logic            last_iter;

    // Sign fix-up.
    logic            op_signed;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    // Decode the incoming request and form operand magnitudes.
    always_comb begin
        in_signed = ~bus.op[0];
        in_rem    = bus.op[1];
        in_b_zero = (bus.B == '0);
        in_ovf    = in_signed && (bus.A == {1'b1, {(XLEN-1){1'b0}}}) && (bus.B == '1);
        in_a_mag  = (in_signed && bus.A[XLEN-1]) ? -bus.A : bus.A;
        in_b_mag  = (in_signed && bus.B[XLEN-1]) ? -bus.B : bus.B;
    end

    // Trial subtraction of the divisor from the shifted partial remainder, and the sign fix-up.
    always_comb begin
        // Two guard bits: the shifted remainder needs XLEN+1 bits and the sign one more.
        trial     = {1'b0, rem_q, quo_q[XLEN-1]} - {2'b00, dvs_q};
        // A non-negative difference is always below the divisor, so both top bits are clear.
        trial_ok  = (trial[XLEN+1:XLEN] == 2'b00);
        rem_shift = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        last_iter = (cnt_q == CntW'(XLEN - 1));
        op_signed = ~op_q[0];
        quo_fix   = (op_signed && (a_neg_q ^ b_neg_q)) ? -quo_q : quo_q;
        rem_fix   = (op_signed && a_neg_q) ? -rem_q : rem_q;
    end

    // State register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = (in_b_zero || in_ovf) ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (last_iter) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from state; result and dz come straight from registers.
    always_comb begin
        bus.busy   = (state_q == StCalc) || (state_q == StFix);
        bus.done   = (state_q == StDone);
        bus.result = result_q;
        bus.dz     = dz_q;
    end

    // Datapath: operand capture, one restoring step per CALC cycle, result registration.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        a_neg_q <= in_signed & bus.A[XLEN-1];
                        b_neg_q <= in_signed & bus.B[XLEN-1];
                        if (in_b_zero) begin
                            result_q <= in_rem ? bus.A : '1;
                            dz_q     <= 1'b1;
                        end else if (in_ovf) begin
                            // Quotient of the overflow case is the dividend itself.
                            result_q <= in_rem ? '0 : bus.A;
                            dz_q     <= 1'b0;
                        end else begin
                            // The dividend magnitude sits in quo and shifts into rem bit by bit.
                            rem_q <= '0;
                            quo_q <= in_a_mag;
                            dvs_q <= in_b_mag;
                            cnt_q <= '0;
                        end
                    end
                end
                StCalc: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (trial_ok) begin
                        rem_q <= trial[XLEN-1:0];
                        quo_q <= {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_q <= rem_shift;
                        quo_q <= {quo_q[XLEN-2:0], 1'b0};
                    end
                end
                StFix: begin
                    result_q <= op_q[1] ? rem_fix : quo_fix;
                    dz_q     <= 1'b0;
                end
                StDone: begin
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected responses, a negedge monitor
// pops and compares result, dz, completion cycle and busy length on every done pulse.
module tb_div_unit;
    localparam logic [1:0] OpDiv  = 2'b00;
    localparam logic [1:0] OpDivu = 2'b01;
    localparam logic [1:0] OpRem  = 2'b10;
    localparam logic [1:0] OpRemu = 2'b11;

    typedef struct {
        logic [31:0] res;
        logic        dz;
        int          done_cyc;
        int          busy_len;
    } exp_t;

    logic clk  = 1'b0;
    logic nRst = 1'b1;

    always #5 clk = ~clk;

    div_unit_if #(.XLEN(32)) bus ();

    div_unit #(.XLEN(32)) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: count busy cycles, and on each done pop the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!nRst) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_done: got done=1 at cycle %0d expected no done", cyc);
                end else begin
                    e = sb.pop_front();
                    check("result", bus.result, e.res);
                    check("dz", {31'd0, bus.dz}, {31'd0, e.dz});
                    check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    check("busy_len", 32'(busy_cnt), 32'(e.busy_len));
                end
                busy_cnt = 0;
                done_cnt++;
            end
        end
    end

    // Drive one request for one cycle and push its expected response.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic dz, input bit special);
        exp_t e;
        e.res      = res;
        e.dz       = dz;
        e.done_cyc = cyc + 1 + (special ? 0 : 33);
        e.busy_len = special ? 0 : 33;
        sb.push_back(e);
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = 32'hDEAD_BEEF;
        bus.B     = 32'h1234_5678;
    endtask

    // Wait (bounded) for the monitor to see the next done pulse.
    task automatic wait_done(input string name);
        int n0;
        n0 = done_cnt;
        for (int i = 0; i < 60 && done_cnt == n0; i++) begin
            @(posedge clk);
            #1;
        end
        if (done_cnt == n0) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: got no done expected done within 60 cycles", name);
        end
    endtask

    task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic dz,
                       input bit special);
        issue(op, a, b, res, dz, special);
        wait_done(name);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.A     = '0;
        bus.B     = '0;
        #2 nRst = 1'b0;
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_dz", {31'd0, bus.dz}, 32'd0);
        repeat (2) @(posedge clk);
        #1 nRst = 1'b1;
        @(posedge clk);
        #1;

        // Unsigned and signed normal operations.
        run("divu_100_7", OpDivu, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
        run("remu_100_7", OpRemu, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);
        run("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run("rem_m7_2", OpRem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run("div_7_m2", OpDiv, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run("rem_7_m2", OpRem, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0);

        // Divide by zero and signed overflow complete the cycle after the start edge.
        run("div_5_0", OpDiv, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);
        run("remu_5_0", OpRemu, 32'd5, 32'd0, 32'd5, 1'b1, 1'b1);
        run("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
        run("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);

        // Boundary operands that take the full iterative path.
        run("divu_max_1", OpDivu, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run("divu_min_3", OpDivu, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 1'b0, 1'b0);
        run("remu_min_3", OpRemu, 32'h8000_0000, 32'd3, 32'd2, 1'b0, 1'b0);
        run("div_min_2", OpDiv, 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0, 1'b0);

        // A start while busy must be ignored; the next request goes in the IDLE after done.
        issue(OpDivu, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        bus.op    = OpRemu;
        bus.A     = 32'd50;
        bus.B     = 32'd5;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("ignore_start");
        run("back_to_back", OpRem, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0);

        // Reset in the middle of CALC abandons the operation with no done.
        issue(OpDivu, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        nRst = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_done", {31'd0, bus.done}, 32'd0);
        check("mid_rst_result", bus.result, 32'd0);
        check("mid_rst_dz", {31'd0, bus.dz}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1 nRst = 1'b1;
        @(posedge clk);
        #1;
        run("divu_9_3", OpDivu, 32'd9, 32'd3, 32'd3, 1'b0, 1'b0);

        // Quiet period: any stray done would be flagged by the monitor.
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
